jtpopeye_ps2_keyrx: RTL and testbench

- Receives a raw PS/2 keyboard serial stream and produces the 11-bit ps2_key event word that the platform top decodes into cabinet buttons. Word format: bit10 = toggle, bit9 = pressed, bit8 = extended, bits7:0 = scan code.
- Handles sync, deglitch, framing, odd parity, E0/F0 prefixes, E1 (Pause) skip, and a mid-frame timeout.
- Sits between the board PS/2 pins and the keyboard decoding logic, so builds without an HPS bridge still get keyboard input.

---
 rtl/jtpopeye_ps2_keyrx_if.sv | 22 ++
 rtl/jtpopeye_ps2_keyrx.sv | 173 +++++++++++++++++
 tb/tb_jtpopeye_ps2_keyrx.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpopeye_ps2_keyrx_if.sv
// PS/2 receive bundle: raw pins in, decoded key event word and framing error pulse out.
// The master drives the pins (board / bench); the slave is the receiver.
interface jtpopeye_ps2_keyrx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  ps2_key,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output frame_err
  );
endinterface

// File: rtl/jtpopeye_ps2_keyrx.sv
// PS/2 keyboard receiver: sync + deglitch, 11-bit frame capture with odd parity, E0/F0/E1 prefix handling.
// ps2_key updates 2 clk after the stop-bit fall strobe; no backpressure, the pins are receive-only.
module jtpopeye_ps2_keyrx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 40000,
  parameter int TOW     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jtpopeye_ps2_keyrx_if.slave    bus
);

  localparam int             FLW     = $clog2(FILTER + 1);
  localparam logic [FLW-1:0] FLT_LIM = FLW'(FILTER - 1);
  localparam logic [TOW-1:0] TMO_LIM = TOW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0]          s1_q, s2_q, flt_q;
  logic [1:0][FLW-1:0] fcnt_q;
  logic                ck_prev_q;
  logic                fall;
  logic                dat;

  state_t      state_q, state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  shf_q, shf_d;
  logic        par_q, par_d;
  logic [TOW-1:0] tmo_q, tmo_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [2:0]  skip_q, skip_d;
  logic        bvld_q, bvld_d;
  logic [10:0] key_q, key_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      flt_q     <= 2'b11;
      fcnt_q    <= '0;
      ck_prev_q <= 1'b1;
    end else begin
      s1_q      <= {bus.ps2_data, bus.ps2_clk};
      s2_q      <= s1_q;
      ck_prev_q <= flt_q[0];
      // A new level must persist FILTER cycles before it is accepted
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == flt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FLT_LIM) begin
          fcnt_q[i] <= '0;
          flt_q[i]  <= s2_q[i];
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall = ck_prev_q & ~flt_q[0];
  assign dat  = flt_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shf_q   <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      skip_q  <= '0;
      bvld_q  <= 1'b0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shf_q   <= shf_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      skip_q  <= skip_d;
      bvld_q  <= bvld_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shf_d   = shf_q;
    par_d   = par_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    key_d   = key_q;
    bvld_d  = 1'b0;
    err_d   = 1'b0;
    tmo_d   = (fall || state_q == IDLE) ? '0 : tmo_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (fall && !dat) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shf_d  = {dat, shf_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (dat && (^{shf_q, par_q})) begin
            bvld_d = 1'b1;
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fall on the same cycle wins over the timeout
    if (!fall && state_q != IDLE && tmo_q == TMO_LIM) begin
      state_d = IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end

    // shf_q is stable here: the next frame cannot shift a bit for many cycles
    if (bvld_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (shf_q == 8'hE1) begin
        skip_d = 3'd7;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end else if (shf_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shf_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        key_d = {~key_q[10], ~brk_q, ext_q, shf_q};
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_jtpopeye_ps2_keyrx.sv
// Directed bench for the PS/2 key receiver: frames are bit-banged on the pins and the event word checked.
module tb_jtpopeye_ps2_keyrx;
  localparam int HALF    = 30;
  localparam int GAP     = 40;
  localparam int TIMEOUT = 40000;

  logic clk;
  logic rst_n;
  jtpopeye_ps2_keyrx_if bus ();

  jtpopeye_ps2_keyrx #(.FILTER(8), .TIMEOUT(TIMEOUT), .TOW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #12 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int err_pulses = 0;
  int err_run    = 0;
  int err_maxrun = 0;
  int err_cyc    = 0;
  int last_fall  = 0;
  logic err_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) begin
      if (!err_prev) begin
        err_pulses++;
        err_cyc = cyc;
      end
      err_run++;
      if (err_run > err_maxrun) err_maxrun = err_run;
    end else begin
      err_run = 0;
    end
    err_prev = bus.frame_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Sends the first nbits of an 11-bit frame {stop, parity, data, start}
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit glitch, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      wait_clk(HALF);
      bus.ps2_clk = 1'b0;
      last_fall = cyc;
      wait_clk(HALF);
      bus.ps2_clk = 1'b1;
      if (glitch && i == 4) begin
        wait_clk(10);
        bus.ps2_clk = 1'b0;
        wait_clk(3);
        bus.ps2_clk = 1'b1;
      end
    end
    bus.ps2_data = 1'b1;
    wait_clk(GAP);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b0, 1'b0, 11);
  endtask

  task automatic test_reset;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n = 1'b0;
    wait_clk(5);
    @(negedge clk);
    total++;
    if (bus.ps2_key !== 11'h000) begin
      $display("FAIL reset_key: got %h want 000", bus.ps2_key); bad++;
    end
    total++;
    if (bus.frame_err !== 1'b0) begin
      $display("FAIL reset_err: got %b want 0", bus.frame_err); bad++;
    end
    rst_n = 1'b1;
    wait_clk(20);
  endtask

  task automatic test_make;
    int e0;
    e0 = err_pulses;
    send(8'h1C);
    total++;
    if (bus.ps2_key !== 11'h61C) begin
      $display("FAIL make_1c: got %h want 61C", bus.ps2_key); bad++;
    end
    total++;
    if (err_pulses !== e0) begin
      $display("FAIL make_noerr: got %0d pulses want %0d", err_pulses, e0); bad++;
    end
  endtask

  task automatic test_break;
    send(8'hF0);
    total++;
    if (bus.ps2_key !== 11'h61C) begin
      $display("FAIL brk_prefix_hold: got %h want 61C", bus.ps2_key); bad++;
    end
    send(8'h1C);
    total++;
    if (bus.ps2_key !== 11'h01C) begin
      $display("FAIL brk_1c: got %h want 01C", bus.ps2_key); bad++;
    end
  endtask

  task automatic test_extended;
    send(8'hE0); send(8'h75);
    total++;
    if (bus.ps2_key !== 11'h775) begin
      $display("FAIL ext_make: got %h want 775", bus.ps2_key); bad++;
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    total++;
    if (bus.ps2_key !== 11'h175) begin
      $display("FAIL ext_break: got %h want 175", bus.ps2_key); bad++;
    end
    send(8'h14);
    total++;
    if (bus.ps2_key !== 11'h614) begin
      $display("FAIL ext_cleared: got %h want 614", bus.ps2_key); bad++;
    end
  endtask

  task automatic test_bad_frame;
    int e0;
    e0 = err_pulses;
    send_bits(8'h14, 1'b1, 1'b0, 1'b0, 11);
    total++;
    if (err_pulses !== e0 + 1) begin
      $display("FAIL parity_err: got %0d pulses want %0d", err_pulses, e0 + 1); bad++;
    end
    total++;
    if (bus.ps2_key !== 11'h614) begin
      $display("FAIL parity_hold: got %h want 614", bus.ps2_key); bad++;
    end
    send(8'h14);
    total++;
    if (bus.ps2_key !== 11'h214) begin
      $display("FAIL parity_next: got %h want 214", bus.ps2_key); bad++;
    end
    // E0 is dropped by the following stop-bit error
    send(8'hE0);
    send_bits(8'h14, 1'b0, 1'b1, 1'b0, 11);
    total++;
    if (err_pulses !== e0 + 2) begin
      $display("FAIL stop_err: got %0d pulses want %0d", err_pulses, e0 + 2); bad++;
    end
    send(8'h14);
    total++;
    if (bus.ps2_key !== 11'h614) begin
      $display("FAIL stop_ext_clr: got %h want 614", bus.ps2_key); bad++;
    end
  endtask

  task automatic test_timeout;
    int e0;
    int dly;
    e0 = err_pulses;
    send_bits(8'h05, 1'b0, 1'b0, 1'b0, 5);
    wait_clk(45000);
    dly = err_cyc - last_fall;
    total++;
    if (err_pulses !== e0 + 1) begin
      $display("FAIL tmo_err: got %0d pulses want %0d", err_pulses, e0 + 1); bad++;
    end
    total++;
    if (dly < TIMEOUT || dly > TIMEOUT + 20) begin
      $display("FAIL tmo_delay: got %0d cycles want %0d..%0d", dly, TIMEOUT, TIMEOUT + 20); bad++;
    end
    total++;
    if (bus.ps2_key !== 11'h614) begin
      $display("FAIL tmo_hold: got %h want 614", bus.ps2_key); bad++;
    end
    send(8'h05);
    total++;
    if (bus.ps2_key !== 11'h205) begin
      $display("FAIL tmo_next: got %h want 205", bus.ps2_key); bad++;
    end
  endtask

  task automatic test_pause;
    logic [7:0] seq [8];
    int changed;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    changed = 0;
    for (int i = 0; i < 8; i++) begin
      send(seq[i]);
      if (bus.ps2_key !== 11'h205) changed++;
    end
    total++;
    if (changed !== 0) begin
      $display("FAIL pause_skip: got %0d changed bytes want 0 (key %h)", changed, bus.ps2_key); bad++;
    end
    send(8'h06);
    total++;
    if (bus.ps2_key !== 11'h606) begin
      $display("FAIL pause_after: got %h want 606", bus.ps2_key); bad++;
    end
  endtask

  task automatic test_glitch_passthru;
    send_bits(8'h33, 1'b0, 1'b0, 1'b1, 11);
    total++;
    if (bus.ps2_key !== 11'h233) begin
      $display("FAIL glitch: got %h want 233", bus.ps2_key); bad++;
    end
    send(8'hAA);
    total++;
    if (bus.ps2_key !== 11'h6AA) begin
      $display("FAIL bat_aa: got %h want 6AA", bus.ps2_key); bad++;
    end
    send(8'hFA);
    total++;
    if (bus.ps2_key !== 11'h2FA) begin
      $display("FAIL ack_fa: got %h want 2FA", bus.ps2_key); bad++;
    end
  endtask

  task automatic test_reset_midframe;
    send_bits(8'h1C, 1'b0, 1'b0, 1'b0, 6);
    rst_n = 1'b0;
    wait_clk(4);
    @(negedge clk);
    total++;
    if (bus.ps2_key !== 11'h000) begin
      $display("FAIL midrst_key: got %h want 000", bus.ps2_key); bad++;
    end
    rst_n = 1'b1;
    wait_clk(20);
    send(8'h1C);
    total++;
    if (bus.ps2_key !== 11'h61C) begin
      $display("FAIL midrst_next: got %h want 61C", bus.ps2_key); bad++;
    end
    total++;
    if (err_maxrun !== 1) begin
      $display("FAIL err_width: got %0d cycles want 1", err_maxrun); bad++;
    end
  endtask

  initial begin
    test_reset;
    test_make;
    test_break;
    test_extended;
    test_bad_frame;
    test_timeout;
    test_pause;
    test_glitch_passthru;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
